// File: rtl/mac_acc_pkg.sv
// Shared types and constants for the two-lane MAC accumulator.
// The lane count and data width are fixed here for every file that imports this package.
package mac_acc_pkg;

    localparam int NLANES = 2;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Sign-extended sum with one guard bit, used to detect signed overflow
    function automatic logic [DATA_W:0] add_ext(
        input logic [DATA_W-1:0] a,
        input logic [DATA_W-1:0] b
    );
        return {a[DATA_W-1], a} + {b[DATA_W-1], b};
    endfunction

endpackage

// File: rtl/mac_acc_lane.sv
// One accumulator lane: register, adder, optional clamp and sticky overflow flag.
// Define MAC_ACC_SAT_EN for saturating addition; without it the lane wraps and o_ovf is 0.
module mac_acc_lane
    import mac_acc_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_clr,
    input  logic              i_en,
    input  logic [DATA_W-1:0] i_sum,
    output logic [DATA_W-1:0] o_acc,
    output logic              o_ovf
);

    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] w_next;

`ifdef MAC_ACC_SAT_EN
    logic [DATA_W:0] w_ext;
    logic            w_clamp;
    logic            r_ovf;

    // Guard bit disagreeing with the result MSB means signed overflow
    always_comb begin
        w_ext   = add_ext(r_acc, i_sum);
        w_clamp = w_ext[DATA_W] != w_ext[DATA_W-1];
        w_next  = w_ext[DATA_W-1:0];
        if (w_clamp) begin
            w_next = w_ext[DATA_W] ? {1'b1, {(DATA_W-1){1'b0}}}
                                   : {1'b0, {(DATA_W-1){1'b1}}};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ovf <= 1'b0;
        end else if (i_clr) begin
            r_ovf <= 1'b0;
        end else if (i_en && w_clamp) begin
            r_ovf <= 1'b1;
        end
    end

    assign o_ovf = r_ovf;
`else
    assign w_next = r_acc + i_sum;
    assign o_ovf  = 1'b0;
`endif

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_acc <= '0;
        end else if (i_clr) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= w_next;
        end
    end

    assign o_acc = r_acc;

endmodule

// File: rtl/mac_accumulator.sv
// Two-lane signed accumulator over a counted burst of beats, result held until taken.
// Define MAC_ACC_SAT_EN to build saturating lanes with sticky ovf_o flags.
module mac_accumulator
    import mac_acc_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           start_i,
    input  logic [LEN_W-1:0]               len_i,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [NLANES-1:0][DATA_W-1:0]  sums_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [NLANES-1:0][DATA_W-1:0]  acc_o,
    output logic                           busy_o,
    output logic [NLANES-1:0]              ovf_o
);

    state_t           r_state;
    state_t           w_next;
    logic [LEN_W-1:0] r_cnt;
    logic             w_start;
    logic             w_accept;
    logic             w_last;

    assign w_start  = (r_state == IDLE) && start_i;
    assign w_accept = in_valid_i && in_ready_o;
    assign w_last   = w_accept && (r_cnt == LEN_W'(1));

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (start_i) begin
                    w_next = (len_i == '0) ? DONE : ACCUM;
                end
            end
            ACCUM: begin
                if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                if (out_ready_i) begin
                    w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o  = 1'b0;
        out_valid_o = 1'b0;
        busy_o      = 1'b1;
        unique case (r_state)
            IDLE:    busy_o      = 1'b0;
            ACCUM:   in_ready_o  = 1'b1;
            DONE:    out_valid_o = 1'b1;
            default: busy_o      = 1'b0;
        endcase
    end

    // Beats remaining; reload only from IDLE so a late start_i cannot disturb it
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (w_start) begin
            r_cnt <= len_i;
        end else if (w_accept) begin
            r_cnt <= r_cnt - LEN_W'(1);
        end
    end

    for (genvar g = 0; g < NLANES; g++) begin : g_lane
        mac_acc_lane u_lane (
            .i_clk (clk_i),
            .i_rst (rst_i),
            .i_clr (w_start),
            .i_en  (w_accept),
            .i_sum (sums_i[g]),
            .o_acc (acc_o[g]),
            .o_ovf (ovf_o[g])
        );
    end

endmodule

// File: tb/tb_mac_accumulator.sv
// Randomised scoreboard bench for mac_accumulator with directed corner cases.
// Expected results come from an integer reference model; a monitor checks every presented result.
module tb_mac_accumulator;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              start_i;
    logic [15:0]       len_i;
    logic              in_valid_i;
    logic              in_ready_o;
    logic [1:0][31:0]  sums_i;
    logic              out_valid_o;
    logic              out_ready_i;
    logic [1:0][31:0]  acc_o;
    logic              busy_o;
    logic [1:0]        ovf_o;

    mac_accumulator #(.LEN_W(16)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .start_i     (start_i),
        .len_i       (len_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .sums_i      (sums_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .acc_o       (acc_o),
        .busy_o      (busy_o),
        .ovf_o       (ovf_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  ovf;
    } exp_t;

    exp_t        sb[$];
    exp_t        last_exp;
    logic [31:0] b0[$];
    logic [31:0] b1[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: exact integer sum per lane, then clamp or wrap to 32 bits
    function automatic logic [31:0] model_add(input logic [31:0] a,
                                              input logic [31:0] b,
                                              inout logic ovf);
        longint t;
        t = longint'($signed(a)) + longint'($signed(b));
`ifdef MAC_ACC_SAT_EN
        if (t > 64'sd2147483647) begin
            t = 64'sd2147483647;
            ovf = 1'b1;
        end else if (t < -64'sd2147483648) begin
            t = -64'sd2147483648;
            ovf = 1'b1;
        end
`endif
        return t[31:0];
    endfunction

    // Monitor: compare whenever a result is presented, pop on handshake
    always @(negedge clk_i) begin
        if (!rst_i && out_valid_o) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_result: got %h none expected", acc_o);
            end else begin
                check("mon_acc", {acc_o[1], acc_o[0]}, {sb[0].a1, sb[0].a0});
                check("mon_ovf", 64'(ovf_o), 64'(sb[0].ovf));
                check("mon_busy", 64'(busy_o), 64'd1);
                if (out_ready_i) begin
                    void'(sb.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic send_beat(input logic [31:0] s0, input logic [31:0] s1);
        int t = 0;
        while (!in_ready_o && t < 50) begin
            tick();
            t++;
        end
        if (t == 50) begin
            n_cmp++;
            n_bad++;
            $display("FAIL ready_timeout: got in_ready 0 expected 1");
        end
        in_valid_i = 1'b1;
        sums_i     = {s1, s0};
        tick();
        in_valid_i = 1'b0;
        sums_i     = {32'hDEAD_BEEF, 32'hBAD0_BAD0};
    endtask

    // Beats come from b0/b1; start_i is pulsed mid-burst and during the stall when asked
    task automatic run_txn(input int len, input int maxgap, input int stall,
                           input bit st_accum, input bit st_done);
        exp_t e;
        logic o0 = 1'b0;
        logic o1 = 1'b0;
        int   t  = 0;
        e.a0 = '0;
        e.a1 = '0;
        for (int i = 0; i < len; i++) begin
            e.a0 = model_add(e.a0, b0[i], o0);
            e.a1 = model_add(e.a1, b1[i], o1);
        end
        e.ovf = {o1, o0};
        sb.push_back(e);
        start_i = 1'b1;
        len_i   = 16'(len);
        tick();
        start_i = 1'b0;
        len_i   = 16'h00FF;
        check("busy_start", 64'(busy_o), 64'd1);
        if (len == 0) begin
            check("zero_len_valid", 64'(out_valid_o), 64'd1);
            check("zero_len_ready", 64'(in_ready_o), 64'd0);
        end
        for (int i = 0; i < len; i++) begin
            int gap = int'($urandom_range(0, maxgap));
            if (st_accum && i == 1) begin
                gap = gap + 1;
            end
            for (int g = 0; g < gap; g++) begin
                start_i = st_accum && (i == 1);
                len_i   = 16'd7;
                tick();
                start_i = 1'b0;
            end
            send_beat(b0[i], b1[i]);
            if (i == len - 1) begin
                check("latency_valid", 64'(out_valid_o), 64'd1);
            end else begin
                check("early_valid", 64'(out_valid_o), 64'd0);
            end
        end
        for (int s = 0; s < stall; s++) begin
            start_i = st_done;
            tick();
            check("busy_stall", 64'(busy_o), 64'd1);
        end
        start_i     = 1'b0;
        out_ready_i = 1'b1;
        tick();
        while (out_valid_o && t < 20) begin
            tick();
            t++;
        end
        out_ready_i = 1'b0;
        if (t == 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL done_timeout: got out_valid 1 expected 0");
        end
        check("busy_idle", 64'(busy_o), 64'd0);
        check("acc_hold", {acc_o[1], acc_o[0]}, {e.a1, e.a0});
        last_exp = e;
    endtask

    task automatic set_beats(input int len);
        b0.delete();
        b1.delete();
        for (int i = 0; i < len; i++) begin
            b0.push_back($urandom);
            b1.push_back($urandom);
        end
    endtask

    initial begin
        rst_i       = 1'b1;
        start_i     = 1'b0;
        len_i       = '0;
        in_valid_i  = 1'b0;
        sums_i      = '0;
        out_ready_i = 1'b0;
        #12;
        check("rst_acc", {acc_o[1], acc_o[0]}, 64'd0);
        check("rst_flags",
              64'({in_ready_o, out_valid_o, busy_o, ovf_o}), 64'd0);
        rst_i = 1'b0;
        tick();

        // Directed three-beat burst
        b0 = '{32'd5, 32'd7, -32'sd1};
        b1 = '{-32'sd2, 32'd4, 32'd10};
        run_txn(3, 0, 0, 1'b0, 1'b0);
        check("basic_result", {last_exp.a1, last_exp.a0}, {32'd12, 32'd11});

        // Zero-length transaction
        b0.delete();
        b1.delete();
        run_txn(0, 0, 2, 1'b0, 1'b0);

        // Gapped beats, long stall, start_i ignored in ACCUM and DONE
        b0 = '{32'd100, -32'sd300};
        b1 = '{32'd1, 32'd2};
        run_txn(2, 2, 5, 1'b1, 1'b1);

        // Positive overflow on lane 0
        b0 = '{32'h7FFF_FFF0, 32'h0000_0020};
        b1 = '{32'd3, 32'd4};
        run_txn(2, 0, 1, 1'b0, 1'b0);
`ifdef MAC_ACC_SAT_EN
        check("ovf_acc0", 64'(acc_o[0]), 64'h7FFF_FFFF);
        check("ovf_flag", 64'(ovf_o), 64'd1);
`else
        check("wrap_acc0", 64'(acc_o[0]), 64'h8000_0010);
        check("wrap_flag", 64'(ovf_o), 64'd0);
`endif

        // Reset mid-transaction after two of four beats
        set_beats(4);
        start_i = 1'b1;
        len_i   = 16'd4;
        tick();
        start_i = 1'b0;
        send_beat(b0[0], b1[0]);
        send_beat(b0[1], b1[1]);
        rst_i = 1'b1;
        #2;
        check("midrst_acc", {acc_o[1], acc_o[0]}, 64'd0);
        check("midrst_flags",
              64'({in_ready_o, out_valid_o, busy_o, ovf_o}), 64'd0);
        sb.delete();
        tick();
        rst_i = 1'b0;
        tick();
        b0 = '{32'd9};
        b1 = '{32'd9};
        run_txn(1, 0, 0, 1'b0, 1'b0);
        check("post_rst_result", {last_exp.a1, last_exp.a0}, {32'd9, 32'd9});

        // Randomised bursts
        for (int n = 0; n < 25; n++) begin
            int len = int'($urandom_range(1, 6));
            set_beats(len);
            run_txn(len, int'($urandom_range(0, 2)),
                    int'($urandom_range(0, 3)),
                    bit'($urandom_range(0, 1)) && len > 1,
                    bit'($urandom_range(0, 1)));
        end

        tick();
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL sb_leftover: got %0d expected 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter: LEN_W, 16, width of beat-count field len_i.
REQ-002 SHALL have port: clk_i  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port: rst_i  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: start_i  input  1  begin transaction; sampled only in IDLE.
REQ-005 SHALL have port: len_i  input  LEN_W  number of input beats in transaction; captured with start_i.
REQ-006 SHALL have port: in_valid_i  input  1  sums_i valid.
REQ-007 SHALL have port: in_ready_o  output  1  block accepts a beat.
REQ-008 SHALL have port: sums_i  input  2x32  signed lane sums from the adder stage (lane 0, lane 1).
REQ-009 SHALL have port: out_valid_o  output  1  acc_o holds final result.
REQ-010 SHALL have port: out_ready_i  input  1  consumer takes result.
REQ-011 SHALL have port: acc_o  output  2x32  signed per-lane accumulators.
REQ-012 SHALL have port: busy_o  output  1  high in any state other than IDLE.
REQ-013 SHALL have port: ovf_o  output  2  sticky per-lane saturation flag.

Function
REQ-014 SHALL implement FSM states IDLE, ACCUM, DONE.
REQ-015 SHALL move IDLE->ACCUM on start_i with len_i!=0: clear both accumulators, clear ovf_o, load beat counter with len_i.
REQ-016 SHALL move IDLE->DONE on start_i with len_i==0, presenting acc_o = 0 and 0.
REQ-017 SHALL drive in_ready_o=1 only in ACCUM; a beat is accepted when in_valid_i && in_ready_o.
REQ-018 SHALL, per accepted beat, add sums_i[k] to acc[k] for k=0,1 in the same edge and decrement the counter.
REQ-019 SHALL move ACCUM->DONE on the edge accepting the last beat; out_valid_o rises the following cycle (latency 1 from last beat).
REQ-020 SHALL hold out_valid_o, acc_o and ovf_o stable in DONE until out_ready_i; DONE->IDLE on out_valid_o && out_ready_i.
REQ-021 SHALL ignore start_i in ACCUM and DONE (no restart, no clear).
REQ-022 SHALL keep acc_o holding the last value in IDLE after a completed transaction.
REQ-023 SHALL not accept beats in IDLE or DONE; in_valid_i there has no effect.

Reset
REQ-024 SHALL on rst_i asserted, asynchronously force state IDLE, counter 0, acc_o 0, ovf_o 0, in_ready_o 0, out_valid_o 0, busy_o 0, including mid-transaction.
REQ-025 SHALL resume normal operation the first edge after rst_i deasserts; partial results are discarded.

Configuration
REQ-026 SHALL with macro MAC_ACC_SAT_EN defined, perform signed saturating addition per lane (clamp to 0x7FFFFFFF / 0x80000000) and set ovf_o[k] sticky on any clamp of lane k.
REQ-027 SHALL without MAC_ACC_SAT_EN, perform 32-bit two's-complement wrap addition and tie ovf_o to 0.

Structure
REQ-028 SHALL place the FSM state enum and the lane count constant (2) in shared package mac_acc_pkg.
REQ-029 SHALL instantiate one sub-module mac_acc_lane per lane (accumulator register, add, optional saturation, ovf flag).

Verification
REQ-030 SHALL cover: start_i, len_i=3, beats (5,-2),(7,4),(-1,10), out_ready_i=1 -> acc_o=(11,12), out_valid_o one cycle after third beat.
REQ-031 SHALL cover: len_i=0 -> DONE next cycle, acc_o=(0,0), in_ready_o never high.
REQ-032 SHALL cover: len_i=2, in_valid_i gaps, out_ready_i low 5 cycles -> acc_o stable during stall, busy_o high until handshake.
REQ-033 SHALL cover: MAC_ACC_SAT_EN, lane0 beats 0x7FFFFFF0,+0x20 -> acc_o[0]=0x7FFFFFFF, ovf_o=01; without macro -> acc_o[0]=0x80000010, ovf_o=00.
REQ-034 SHALL cover: rst_i pulsed after second of four beats -> all outputs 0, IDLE; new start_i len_i=1 beat (9,9) -> acc_o=(9,9).
REQ-035 SHALL cover: start_i asserted during ACCUM and DONE -> ignored, counter and accumulators unaffected.
